// File: rtl/move_input_controller_if.sv
// Move handshake bundle between the button controller and the game logic.
// The master drives move_valid, dir and conflict; the slave answers with move_ready.
interface move_input_controller_if;
  logic       move_valid;
  logic       move_ready;
  logic [1:0] dir;
  logic       conflict;

  modport master (output move_valid, output dir, output conflict, input move_ready);
  modport slave  (input move_valid, input dir, input conflict, output move_ready);
endinterface

// File: rtl/move_input_controller.sv
// Four-button move input: per-button sync + debounce, then a press-to-move FSM
// issuing exactly one valid/ready handshake per press and flagging multi-presses.

module mic_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        // Next increment would reach the threshold: accept the new level.
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module move_input_controller #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           btn_up,
  input  logic                           btn_right,
  input  logic                           btn_down,
  input  logic                           btn_left,
  move_input_controller_if.master        move
);
  localparam int NUM_BTN = 4;

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] ISSUE        = 2'd1;
  localparam logic [1:0] WAIT_RELEASE = 2'd2;
  localparam logic [1:0] LOCKOUT      = 2'd3;

  logic [NUM_BTN-1:0] btn, deb;
  logic [1:0]         state, enc;
  logic               move_valid_q, conflict_q;
  logic [1:0]         dir_q;

  // Bit index doubles as the direction code.
  assign btn = {btn_left, btn_down, btn_right, btn_up};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    mic_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn[i]),
      .level (deb[i])
    );
  end

  always_comb begin
    enc = 2'd0;
    for (int i = 0; i < NUM_BTN; i++)
      if (deb[i]) enc = 2'(i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      move_valid_q <= 1'b0;
      dir_q        <= 2'd0;
      conflict_q   <= 1'b0;
    end else begin
      conflict_q <= 1'b0;
      case (state)
        IDLE: begin
          if ($onehot(deb)) begin
            dir_q        <= enc;
            move_valid_q <= 1'b1;
            state        <= ISSUE;
          end else if (deb != '0) begin
            conflict_q <= 1'b1;
            state      <= LOCKOUT;
          end
        end
        ISSUE: begin
          // Offer is frozen until accepted; button activity is ignored here.
          if (move.move_ready) begin
            move_valid_q <= 1'b0;
            state        <= WAIT_RELEASE;
          end
        end
        default: begin
          if (deb == '0) state <= IDLE;
        end
      endcase
    end
  end

  assign move.move_valid = move_valid_q;
  assign move.dir        = dir_q;
  assign move.conflict   = conflict_q;
endmodule

// File: tb/tb_move_input_controller.sv
// Directed bench for move_input_controller with DEBOUNCE_CYCLES = 4:
// latency, bounce rejection, back-pressure, conflict, reset-in-ISSUE, no auto-repeat.
module tb_move_input_controller;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst, btn_up, btn_right, btn_down, btn_left;
  int   n_cmp = 0;
  int   n_bad = 0;

  move_input_controller_if mif ();

  move_input_controller #(.DEBOUNCE_CYCLES(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_up    (btn_up),
    .btn_right (btn_right),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .move      (mif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Idle quiet period: nothing offered, nothing flagged.
  task automatic quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk(tag, {3'b0, mif.move_valid}, 4'h0);
      chk(tag, {3'b0, mif.conflict}, 4'h0);
    end
  endtask

  // Button already driven after an edge: valid reads 1 only after the 7th edge.
  task automatic expect_move(input string tag, input logic [1:0] d);
    for (int i = 0; i < D + 2; i++) begin
      tick();
      chk({tag, "_pre"}, {3'b0, mif.move_valid}, 4'h0);
    end
    tick();
    chk({tag, "_valid"}, {3'b0, mif.move_valid}, 4'h1);
    chk({tag, "_dir"}, {2'b0, mif.dir}, {2'b0, d});
  endtask

  initial begin
    rst = 1'b1; btn_up = 0; btn_right = 0; btn_down = 0; btn_left = 0;
    mif.move_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", {3'b0, mif.move_valid}, 4'h0);
    chk("rst_dir", {2'b0, mif.dir}, 4'h0);
    chk("rst_conflict", {3'b0, mif.conflict}, 4'h0);
    rst = 1'b0;
    quiet("idle", 3);

    // Left held, ready high: one-cycle move, no repeat while held.
    mif.move_ready = 1'b1;
    btn_left = 1'b1;
    expect_move("left", 2'd3);
    tick();
    chk("left_drop", {3'b0, mif.move_valid}, 4'h0);
    quiet("left_hold", 10);
    btn_left = 1'b0;
    quiet("left_rel", 10);
    btn_left = 1'b1;
    expect_move("left_again", 2'd3);
    tick();
    chk("left_again_drop", {3'b0, mif.move_valid}, 4'h0);
    btn_left = 1'b0;
    quiet("left_again_rel", 10);

    // Bouncing up every 2 cycles never debounces.
    for (int i = 0; i < 20; i++) begin
      btn_up = ~btn_up;
      quiet("bounce", 2);
    end
    btn_up = 1'b0;
    quiet("bounce_rel", 10);

    // Down with back-pressure: 11 valid cycles, dir frozen through button changes.
    mif.move_ready = 1'b0;
    btn_down = 1'b1;
    expect_move("down", 2'd2);
    for (int i = 0; i < 10; i++) begin
      if (i == 2) btn_down = 1'b0;
      if (i == 4) begin btn_left = 1'b1; btn_right = 1'b1; end
      tick();
      chk("down_hold_valid", {3'b0, mif.move_valid}, 4'h1);
      chk("down_hold_dir", {2'b0, mif.dir}, 4'h2);
      chk("down_hold_conflict", {3'b0, mif.conflict}, 4'h0);
    end
    mif.move_ready = 1'b1;
    tick();
    chk("down_handshake", {3'b0, mif.move_valid}, 4'h0);
    quiet("down_after", 8);
    btn_left = 1'b0; btn_right = 1'b0;
    quiet("down_rel", 10);

    // Simultaneous up+right: single conflict pulse, then right alone works.
    btn_up = 1'b1; btn_right = 1'b1;
    for (int i = 0; i < D + 2; i++) begin
      tick();
      chk("conf_pre", {3'b0, mif.conflict}, 4'h0);
    end
    tick();
    chk("conf_pulse", {3'b0, mif.conflict}, 4'h1);
    chk("conf_novalid", {3'b0, mif.move_valid}, 4'h0);
    quiet("conf_after", 6);
    btn_up = 1'b0; btn_right = 1'b0;
    quiet("conf_rel", 10);
    btn_right = 1'b1;
    expect_move("right", 2'd1);
    tick();
    chk("right_drop", {3'b0, mif.move_valid}, 4'h0);
    btn_right = 1'b0;
    quiet("right_rel", 10);

    // Reset while offering: valid drops, right re-debounced into one fresh move.
    mif.move_ready = 1'b0;
    btn_right = 1'b1;
    expect_move("pre_rst", 2'd1);
    rst = 1'b1;
    tick();
    chk("rst_issue_valid", {3'b0, mif.move_valid}, 4'h0);
    chk("rst_issue_dir", {2'b0, mif.dir}, 4'h0);
    rst = 1'b0;
    expect_move("post_rst", 2'd1);
    mif.move_ready = 1'b1;
    tick();
    chk("post_rst_drop", {3'b0, mif.move_valid}, 4'h0);

    // Right still held after handshake, left added: nothing until all released.
    btn_left = 1'b1;
    quiet("add_left", 15);
    btn_left = 1'b0; btn_right = 1'b0;
    quiet("all_rel", 10);
    btn_left = 1'b1;
    expect_move("left_final", 2'd3);
    tick();
    chk("left_final_drop", {3'b0, mif.move_valid}, 4'h0);
    btn_left = 1'b0;
    quiet("final", 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/move_input_controller.md
MOVE_INPUT_CONTROLLER -- requirements
Module: move_input_controller

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, consecutive stable cycles required before a button level is accepted (legal range 1..2^20-1).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port btn_up  input  1  raw asynchronous button, 1 = pressed.
REQ-005 SHALL have port btn_right  input  1  raw asynchronous button, 1 = pressed.
REQ-006 SHALL have port btn_down  input  1  raw asynchronous button, 1 = pressed.
REQ-007 SHALL have port btn_left  input  1  raw asynchronous button, 1 = pressed.
REQ-008 SHALL have port move_ready  input  1  downstream game controller can accept a move.
REQ-009 SHALL have port move_valid  output  1  a move is offered on dir.
REQ-010 SHALL have port dir  output  2  move direction: 0 = up, 1 = right, 2 = down, 3 = left.
REQ-011 SHALL have port conflict  output  1  one-cycle pulse when a multi-button press is rejected.

Function
REQ-012 SHALL pass each raw button through a 2-flop synchronizer before any other use.
REQ-013 SHALL give each button a debounce counter: increment each cycle the synchronized level differs from the debounced level; clear when equal; when the increment would reach DEBOUNCE_CYCLES, toggle the debounced level and clear the counter.
REQ-014 SHALL size each counter to hold DEBOUNCE_CYCLES without wrap; a counter never exceeds DEBOUNCE_CYCLES.
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT_RELEASE, LOCKOUT.
REQ-016 IDLE: exactly one debounced button pressed -> latch its code into dir, go ISSUE; two or more pressed in the same cycle -> pulse conflict, go LOCKOUT; none -> stay.
REQ-017 ISSUE: move_valid = 1; dir SHALL stay constant; move_valid and move_ready both high at a rising edge = handshake -> WAIT_RELEASE.
REQ-018 ISSUE SHALL hold indefinitely while move_ready = 0; releasing or adding buttons during ISSUE SHALL NOT cancel or change the offered move.
REQ-019 WAIT_RELEASE and LOCKOUT: move_valid = 0; go IDLE in the cycle after all four debounced levels read 0.
REQ-020 Exactly one handshake SHALL occur per press; holding a button SHALL NOT auto-repeat.
REQ-021 Latency: with the raw input steady from sampling edge k, move_valid SHALL first read 1 after edge k+DEBOUNCE_CYCLES+2 (FSM in IDLE, all other buttons released).
REQ-022 move_valid SHALL be registered and SHALL depend on FSM state only, not combinationally on move_ready.
REQ-023 Bounces shorter than DEBOUNCE_CYCLES consecutive cycles SHALL produce no debounced change and no move.
REQ-024 conflict SHALL be high for exactly one cycle per IDLE->LOCKOUT transition and 0 otherwise.

Reset
REQ-025 On rst = 1 at a rising edge: FSM -> IDLE, move_valid = 0, dir = 0, conflict = 0, synchronizers, debounced levels and counters = 0.
REQ-026 Reset during ISSUE SHALL drop move_valid in the following cycle with no handshake; a button still held after reset SHALL be debounced afresh and yield one new move.
REQ-027 rst SHALL take priority over every other input in the same cycle.

Verification (DEBOUNCE_CYCLES = 4)
REQ-028 btn_left held steady, move_ready = 1 -> move_valid high after edge k+6 for one cycle, dir = 3, then 0 until release and re-press.
REQ-029 btn_up toggled every 2 cycles for 40 cycles, then released -> move_valid never asserts, conflict stays 0.
REQ-030 btn_down held, move_ready = 0 for 10 cycles then 1 -> move_valid high 11 cycles with dir = 2 throughout; one handshake; buttons released mid-wait do not alter dir.
REQ-031 btn_up and btn_right raised on the same cycle -> conflict pulses once, no move_valid; after release, btn_right alone -> one move with dir = 1.
REQ-032 rst asserted one cycle while in ISSUE with btn_right held -> move_valid 0 next cycle; after DEBOUNCE_CYCLES+2 further edges a fresh move with dir = 1 is offered.
REQ-033 btn_right held through a completed handshake, btn_left then added -> no second move until all buttons released.
